// File: rtl/hci_mem_bank_responder_pkg.sv
// Shared HCI constants and types for the memory-bank responder.
//   DEFAULT_DW / DEFAULT_BW / DEFAULT_AW : default bank data, byte and address widths
//   HCI_STALL_LFSR_TAPS                  : tap mask of the 16-bit stall LFSR (x^16+x^14+x^13+x^11)
//   hci_stall_level_t                    : 4-bit stall threshold type
//   hci_lfsr_next()                      : one Fibonacci step of the stall LFSR
package hci_package;

  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_BW = 8;
  localparam int unsigned DEFAULT_AW = 32;

  // Taps 16,14,13,11 map to state bits 15,13,12,10.
  localparam logic [15:0] HCI_STALL_LFSR_TAPS = 16'hB400;

  typedef logic [3:0] hci_stall_level_t;

  // Shift left, feed the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] hci_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & HCI_STALL_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hci_mem_bank_responder_bank_model.sv
// One TCDM-like bank: storage, grant with LFSR-driven stalls, bounded stall
// counter and a single-cycle response register.
//   clk_i, rst_i, clear_i : clock, sync active-high reset, sync clear (memory kept)
//   stall_level_i         : stall when lfsr[3:0] < stall_level_i (0 = never)
//   req/gnt/wen/add/be/data/r_data/r_valid : hci_mem slave port (wen=1 is a read)
//   stall_o               : this bank stalled a request this cycle
module hci_mem_bank_model
  import hci_package::*;
#(
  parameter int unsigned DW        = DEFAULT_DW,
  parameter int unsigned BW        = DEFAULT_BW,
  parameter int unsigned AW        = DEFAULT_AW,
  parameter int unsigned AWM       = 12,
  parameter int unsigned MAX_STALL = 7,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  hci_stall_level_t stall_level_i,
  input  logic             req,
  output logic             gnt,
  input  logic             wen,
  input  logic [AW-1:0]    add,
  input  logic [DW/BW-1:0] be,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    r_data,
  output logic             r_valid,
  output logic             stall_o
);

  localparam int unsigned NBE = DW / BW;
  localparam int unsigned SCW = $clog2(MAX_STALL + 1);

  logic [DW-1:0]     mem [0:(1<<AWM)-1];
  logic [15:0]       lfsr;
  logic [SCW-1:0]    scnt;
  logic [AWM-1:0]    widx;
  logic [AW-AWM-1:0] add_unused;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     wr_word;
  logic              stall;

  // Upper address bits are dropped on purpose: addresses alias per bank.
  assign widx       = add[AWM-1:0];
  assign add_unused = add[AW-1:AWM];

  // Once scnt reaches MAX_STALL the stall term is masked, forcing the grant.
  always_comb begin
    stall = req && (stall_level_i != '0) && (lfsr[3:0] < stall_level_i)
            && (scnt < SCW'(MAX_STALL));
    gnt   = req & ~stall;
  end

  assign stall_o = stall;

  // Byte-lane merge of the write data over the current word.
  always_comb begin
    rd_word = mem[widx];
    wr_word = rd_word;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) wr_word[i*BW +: BW] = data[i*BW +: BW];
    end
  end

  // ---- response / control stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lfsr    <= SEED;
      scnt    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      lfsr    <= hci_lfsr_next(lfsr);
      scnt    <= stall ? scnt + SCW'(1) : '0;
      r_valid <= gnt;
      if (gnt) r_data <= rd_word;
    end
  end

  // Storage is never reset; r_data above sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (gnt && !wen) mem[widx] <= wr_word;
  end

`ifndef SYNTHESIS
  logic             hold_q;
  logic             wen_q;
  logic [AW-1:0]    add_q;
  logic [NBE-1:0]   be_q;
  logic [DW-1:0]    data_q;

  always_ff @(posedge clk_i) begin
    hold_q <= req & ~gnt;
    wen_q  <= wen;
    add_q  <= add;
    be_q   <= be;
    data_q <= data;
    if (hold_q && req) begin
      assert (add == add_q && wen == wen_q && be == be_q && data == data_q)
        else $error("hci_mem_bank_model: request changed while stalled");
    end
  end
`endif

endmodule

// File: rtl/hci_mem_bank_responder.sv
// Memory-side responder for the word-interleaved HWPE interconnect:
// NB_BANKS independent TCDM-like banks with pseudo-random grant stalls.
//   clk_i, rst_i, clear_i : clock, sync active-high reset, sync clear (memory kept)
//   stall_level_i         : stall threshold applied to every bank's LFSR
//   stall_cnt_o           : saturating total of stalled request cycles
//   in_*                  : per-bank hci_mem slave signals, index = bank
module hci_mem_bank_responder
  import hci_package::*;
#(
  parameter int unsigned NB_BANKS  = 8,
  parameter int unsigned DW        = DEFAULT_DW,
  parameter int unsigned BW        = DEFAULT_BW,
  parameter int unsigned AWM       = 12,
  parameter int unsigned MAX_STALL = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  hci_stall_level_t                      stall_level_i,
  output logic [31:0]                           stall_cnt_o,
  input  logic [NB_BANKS-1:0]                   in_req,
  output logic [NB_BANKS-1:0]                   in_gnt,
  input  logic [NB_BANKS-1:0]                   in_wen,
  input  logic [NB_BANKS-1:0][DEFAULT_AW-1:0]   in_add,
  input  logic [NB_BANKS-1:0][DW/BW-1:0]        in_be,
  input  logic [NB_BANKS-1:0][DW-1:0]           in_data,
  output logic [NB_BANKS-1:0][DW-1:0]           in_r_data,
  output logic [NB_BANKS-1:0]                   in_r_valid
);

  logic [NB_BANKS-1:0] stall;
  logic [31:0]         pop;
  logic [32:0]         sum;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    hci_mem_bank_model #(
      .DW        (DW),
      .BW        (BW),
      .AW        (DEFAULT_AW),
      .AWM       (AWM),
      .MAX_STALL (MAX_STALL),
      .SEED      (LFSR_SEED ^ 16'(b + 1))
    ) u_bank (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .stall_level_i (stall_level_i),
      .req           (in_req[b]),
      .gnt           (in_gnt[b]),
      .wen           (in_wen[b]),
      .add           (in_add[b]),
      .be            (in_be[b]),
      .data          (in_data[b]),
      .r_data        (in_r_data[b]),
      .r_valid       (in_r_valid[b]),
      .stall_o       (stall[b])
    );
  end

  // One extra bit on the sum detects the wrap so the counter can clamp.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NB_BANKS; i++) pop = pop + 32'(stall[i]);
    sum = {1'b0, stall_cnt_o} + {1'b0, pop};
  end

  // ---- stall statistics stage ----
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) stall_cnt_o <= '0;
    else                  stall_cnt_o <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`ifndef SYNTHESIS
    assert (((NB_BANKS & (NB_BANKS - 1)) == 0) && (MAX_STALL >= 1))
      else $error("hci_mem_bank_responder: bad NB_BANKS or MAX_STALL");
`endif
  end

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
module tb_hci_mem_bank_responder;
  localparam int NB   = 8;
  localparam int AWM  = 12;
  localparam int MAXS = 7;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, clear;
  logic [3:0]           lvl;
  logic [31:0]          scnt_o;
  logic [NB-1:0]        req, gnt, wen, rvalid;
  logic [NB-1:0][31:0]  add, wdata, rdata;
  logic [NB-1:0][3:0]   be;

  int total = 0;
  int bad   = 0;
  int rv_pulses = 0;

  hci_mem_bank_responder #(.NB_BANKS(NB), .AWM(AWM), .MAX_STALL(MAXS), .LFSR_SEED(SEED)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_level_i(lvl), .stall_cnt_o(scnt_o),
    .in_req(req), .in_gnt(gnt), .in_wen(wen), .in_add(add), .in_be(be), .in_data(wdata),
    .in_r_data(rdata), .in_r_valid(rvalid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr [NB];
  int          m_scnt [NB];
  bit          m_rv   [NB];
  logic [31:0] m_rd   [NB];
  bit          m_rdk  [NB];
  logic [31:0] m_mem  [int];   // key = bank*4096 + word address
  longint      m_cnt;
  bit          m_ready = 1'b0;

  logic [NB-1:0] c_pg, c_st;
  logic [31:0]   c_old, c_new;
  bit            c_known;
  int            c_key, c_pop;
  logic [31:0]   n_rd  [NB];
  bit            n_rdk [NB];

  always @(negedge clk) begin
    rv_pulses += $countones(rvalid);
    c_pop = 0;
    for (int b = 0; b < NB; b++) begin
      c_st[b] = req[b] && (lvl != 0) && (m_lfsr[b][3:0] < lvl) && (m_scnt[b] < MAXS);
      c_pg[b] = req[b] && !c_st[b];
      if (c_st[b]) c_pop++;
    end
    if (m_ready) begin
      for (int b = 0; b < NB; b++) begin
        check($sformatf("gnt[%0d]", b), gnt[b], c_pg[b]);
        check($sformatf("r_valid[%0d]", b), rvalid[b], m_rv[b]);
        if (m_rdk[b]) check($sformatf("r_data[%0d]", b), rdata[b], m_rd[b]);
      end
      check("stall_cnt", scnt_o, m_cnt[31:0]);
      // memory effects of this cycle's grants
      for (int b = 0; b < NB; b++) begin
        n_rd[b] = m_rd[b]; n_rdk[b] = m_rdk[b];
        if (c_pg[b]) begin
          c_key   = b * 4096 + int'(add[b] % (1 << AWM));
          c_known = m_mem.exists(c_key);
          c_old   = c_known ? m_mem[c_key] : 32'h0;
          n_rd[b] = c_old; n_rdk[b] = c_known;
          if (!wen[b]) begin
            if (c_known) begin
              c_new = c_old;
              for (int l = 0; l < 4; l++) if (be[b][l]) c_new[l*8 +: 8] = wdata[b][l*8 +: 8];
              m_mem[c_key] = c_new;
            end else if (be[b] == 4'hF) m_mem[c_key] = wdata[b];
          end
        end
      end
    end
    if (rst || clear) begin
      for (int b = 0; b < NB; b++) begin
        m_lfsr[b] = SEED ^ 16'(b + 1);
        m_scnt[b] = 0; m_rv[b] = 0; m_rd[b] = 32'h0; m_rdk[b] = 1;
      end
      m_cnt = 0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      for (int b = 0; b < NB; b++) begin
        m_rv[b] = c_pg[b];
        m_rd[b] = n_rd[b]; m_rdk[b] = n_rdk[b];
        m_scnt[b] = c_st[b] ? m_scnt[b] + 1 : 0;
        m_lfsr[b] = {m_lfsr[b][14:0], m_lfsr[b][15] ^ m_lfsr[b][13] ^ m_lfsr[b][12] ^ m_lfsr[b][10]};
      end
      m_cnt = m_cnt + c_pop;
      if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input int b, input bit is_read, input logic [31:0] a, input logic [3:0] bm,
                        input logic [31:0] d, output logic [31:0] rd, output int waits);
    @(posedge clk); #1;
    req[b] = 1'b1; wen[b] = is_read; add[b] = a; be[b] = bm; wdata[b] = d;
    waits = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (gnt[b]) begin waits = i; break; end
    end
    if (waits < 0) check("gnt_seen", gnt[b], 1);
    @(posedge clk); #1;
    req[b] = 1'b0;
    @(negedge clk);
    check("r_valid_after_gnt", rvalid[b], 1);
    rd = rdata[b];
  endtask

  logic [31:0]   rd, c0, tdata;
  int            waits, rv0;
  logic [NB-1:0] held;

  initial begin
    rst = 1; clear = 0; lvl = 0; req = '0; wen = '0; add = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_r_valid", rvalid, '0);
    check("reset_r_data", rdata, '0);
    check("reset_stall_cnt", scnt_o, 0);

    // full write then read, no stalls
    access(3, 0, 32'd5, 4'hF, 32'hDEADBEEF, rd, waits);
    check("t1_write_wait", waits, 0);
    access(3, 1, 32'd5, 4'h0, 32'h0, rd, waits);
    check("t1_read_wait", waits, 0);
    check("t1_read_data", rd, 32'hDEADBEEF);

    // partial write: its own response is the old word
    access(3, 0, 32'd5, 4'b0101, 32'h11223344, rd, waits);
    check("t2_write_rdata", rd, 32'hDEADBEEF);
    access(3, 1, 32'd5, 4'h0, 32'h0, rd, waits);
    check("t2_merged", rd, 32'hDE22BE44);

    // heavy stalls: bounded wait, counter equals stalled cycles
    lvl = 4'hF;
    c0 = scnt_o;
    access(0, 1, 32'd0, 4'h0, 32'h0, rd, waits);
    check("t3_wait_bounded", (waits >= 0 && waits <= MAXS), 1);
    check("t3_stall_cnt", scnt_o - c0, waits);
    lvl = 4'h0;

    // all banks busy every cycle
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 8; a++) access(b, 0, a, 4'hF, $urandom, rd, waits);
    @(posedge clk); #1;
    rv0 = rv_pulses;
    for (int c = 0; c < 16; c++) begin
      for (int b = 0; b < NB; b++) begin req[b] = 1; wen[b] = 1; add[b] = (c + b) % 8; end
      @(posedge clk); #1;
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("t4_rvalid_pulses", rv_pulses - rv0, 128);

    // reset on the granting edge drops the response, keeps memory
    access(2, 0, 32'd9, 4'hF, 32'hCAFEF00D, rd, waits);
    @(posedge clk); #1;
    req[2] = 1; wen[2] = 1; add[2] = 32'd9; rst = 1;
    @(posedge clk); #1;
    req[2] = 0; rst = 0;
    @(negedge clk);
    check("t5_no_rvalid", rvalid[2], 0);
    check("t5_rdata_zero", rdata[2], 0);
    access(2, 1, 32'd9, 4'h0, 32'h0, rd, waits);
    check("t5_mem_kept", rd, 32'hCAFEF00D);

    // address aliasing above AWM
    access(1, 0, (32'd1 << AWM) + 32'd2, 4'hF, 32'h5A5A1234, rd, waits);
    access(1, 1, 32'd2, 4'h0, 32'h0, rd, waits);
    check("t6_alias", rd, 32'h5A5A1234);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      held = req & ~gnt;
      @(posedge clk); #1;
      clear = 0;
      if (c % 200 == 0) lvl = 4'($urandom_range(0, 15));
      if (held == '0 && $urandom_range(0, 99) == 0) begin
        req = '0; clear = 1;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (!held[b]) begin
            req[b]   = 1'($urandom_range(0, 1));
            wen[b]   = 1'($urandom_range(0, 1));
            tdata    = $urandom;
            add[b]   = ($urandom_range(0, 1) ? (tdata & 32'hFFFF_F000) : 32'h0) | $urandom_range(0, 15);
            be[b]    = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            wdata[b] = $urandom;
          end
        end
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    req = '0; clear = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
